// File: rtl/tile_line_fetcher_pkg.sv
// Shared constants, attribute bit positions and fetch-state encoding for the
// scanline tile fetcher.
package tile_line_fetcher_pkg;

    localparam int unsigned NAME_BASE_DEFAULT    = 0;
    localparam int unsigned ATTR_BASE_DEFAULT    = 1024;
    localparam int unsigned PATTERN_BASE_DEFAULT = 8192;

    localparam int unsigned ATTR_FLIPV = 7;
    localparam int unsigned ATTR_FLIPH = 6;

    localparam int unsigned TILES_PER_ROW  = 32;
    localparam int unsigned BYTES_PER_TILE = 32;

    typedef enum logic [2:0] {
        StIdle,
        StName,
        StAttr,
        StPat0,
        StPat1,
        StPat2,
        StPat3
    } fetch_state_e;

    function automatic logic [7:0] swap_nibbles(logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

endpackage

// File: rtl/tile_line_fetcher_if.sv
// Line request, RAM read port and pixel stream of the tile line fetcher.
interface tile_line_fetcher_if #(
    parameter int unsigned Bits = 16
);
    logic            lineStart;
    logic [7:0]      lineY;
    logic [Bits-1:0] ramAddress;
    logic [7:0]      ramData;
    logic [3:0]      pixel;
    logic            pixelValid;
    logic            pixelReady;
    logic            lineDone;
    logic            busy;

    modport master (
        input  lineStart, lineY, ramData, pixelReady,
        output ramAddress, pixel, pixelValid, lineDone, busy
    );

    modport slave (
        output lineStart, lineY, ramData, pixelReady,
        input  ramAddress, pixel, pixelValid, lineDone, busy
    );
endinterface

// File: rtl/tile_line_fetcher_shifter.sv
// Two-slot pixel buffer (shift presented, hold queued) with the per-line pixel
// counter and the flipH nibble reversal.
module tile_pixel_shifter
    import tile_line_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        flip_h,
    input  logic [31:0] word,
    input  logic        ready,
    output logic        load_ok,
    output logic [3:0]  pixel,
    output logic        valid,
    output logic        last_accept,
    output logic        line_done
);
    logic [31:0] shift_q, hold_q, word_ord;
    logic [3:0]  shift_cnt_q;
    logic        hold_full_q;
    logic [7:0]  pix_cnt_q;
    logic        line_done_q;
    logic        accept, shift_free;

    always_comb begin
        // Bytes already arrive in reversed order under flipH; swapping nibbles
        // completes the full 8-pixel mirror.
        word_ord = flip_h ? {swap_nibbles(word[31:24]), swap_nibbles(word[23:16]),
                             swap_nibbles(word[15:8]),  swap_nibbles(word[7:0])} : word;
        valid       = shift_cnt_q != 4'd0;
        pixel       = shift_q[31:28];
        accept      = valid && ready;
        shift_free  = (shift_cnt_q == 4'd0) || (accept && shift_cnt_q == 4'd1);
        load_ok     = shift_free || !hold_full_q;
        last_accept = accept && (pix_cnt_q == 8'd255);
        line_done   = line_done_q;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q     <= '0;
            hold_q      <= '0;
            shift_cnt_q <= '0;
            hold_full_q <= 1'b0;
            pix_cnt_q   <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= last_accept;
            if (accept) pix_cnt_q <= pix_cnt_q + 8'd1;
            if (shift_free && hold_full_q) begin
                shift_q     <= hold_q;
                shift_cnt_q <= 4'd8;
                hold_full_q <= load;
                if (load) hold_q <= word_ord;
            end else if (shift_free && load) begin
                shift_q     <= word_ord;
                shift_cnt_q <= 4'd8;
            end else begin
                if (accept) begin
                    shift_q     <= {shift_q[27:0], 4'h0};
                    shift_cnt_q <= shift_cnt_q - 4'd1;
                end
                if (load) begin
                    hold_q      <= word_ord;
                    hold_full_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/tile_line_fetcher.sv
// Walks the 32 tiles of one scanline (name, attribute, four pattern bytes)
// and streams 256 pixel indices through tile_pixel_shifter.
module tile_line_fetcher
    import tile_line_fetcher_pkg::*;
#(
    parameter int unsigned Bits        = 16,
    parameter int unsigned NameBase    = NAME_BASE_DEFAULT,
    parameter int unsigned AttrBase    = ATTR_BASE_DEFAULT,
    parameter int unsigned PatternBase = PATTERN_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    tile_line_fetcher_if.master bus
);
    fetch_state_e    state_q;
    logic [4:0]      col_q, tile_row_q;
    logic [2:0]      pix_row_q, row_sel;
    logic [7:0]      tile_q, pat0_q, pat1_q, pat2_q;
    logic            flip_v_q, flip_h_q, busy_q;
    logic [1:0]      byte_sel;
    logic [Bits-1:0] tile_idx, pat_addr;
    logic            load, load_ok, last_accept, line_done;

    always_comb begin
        tile_idx = Bits'({tile_row_q, col_q});
        row_sel  = flip_v_q ? ~pix_row_q : pix_row_q;
        case (state_q)
            StPat1:  byte_sel = 2'd1;
            StPat2:  byte_sel = 2'd2;
            StPat3:  byte_sel = 2'd3;
            default: byte_sel = 2'd0;
        endcase
        byte_sel = byte_sel ^ {2{flip_h_q}};
        pat_addr = Bits'(PatternBase) + Bits'(tile_q) * Bits'(BYTES_PER_TILE)
                 + Bits'({row_sel, byte_sel});
        case (state_q)
            StName:                         bus.ramAddress = Bits'(NameBase) + tile_idx;
            StAttr:                         bus.ramAddress = Bits'(AttrBase) + tile_idx;
            StPat0, StPat1, StPat2, StPat3: bus.ramAddress = pat_addr;
            default:                        bus.ramAddress = '0;
        endcase
        load     = (state_q == StPat3) && load_ok && !bus.lineStart;
        bus.busy = busy_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            col_q      <= '0;
            tile_row_q <= '0;
            pix_row_q  <= '0;
            tile_q     <= '0;
            flip_v_q   <= 1'b0;
            flip_h_q   <= 1'b0;
            pat0_q     <= '0;
            pat1_q     <= '0;
            pat2_q     <= '0;
            busy_q     <= 1'b0;
        end else if (bus.lineStart) begin
            state_q    <= StName;
            col_q      <= '0;
            tile_row_q <= bus.lineY[7:3];
            pix_row_q  <= bus.lineY[2:0];
            busy_q     <= 1'b1;
        end else begin
            if (last_accept) busy_q <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StName: begin
                    tile_q  <= bus.ramData;
                    state_q <= StAttr;
                end
                StAttr: begin
                    flip_v_q <= bus.ramData[ATTR_FLIPV];
                    flip_h_q <= bus.ramData[ATTR_FLIPH];
                    state_q  <= StPat0;
                end
                StPat0: begin pat0_q <= bus.ramData; state_q <= StPat1; end
                StPat1: begin pat1_q <= bus.ramData; state_q <= StPat2; end
                StPat2: begin pat2_q <= bus.ramData; state_q <= StPat3; end
                StPat3: begin
                    // Without a free slot, stay here and keep re-driving the address.
                    if (load_ok) begin
                        col_q   <= col_q + 5'd1;
                        state_q <= (col_q == 5'(TILES_PER_ROW - 1)) ? StIdle : StName;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tile_pixel_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .clear       (bus.lineStart),
        .load        (load),
        .flip_h      (flip_h_q),
        .word        ({pat0_q, pat1_q, pat2_q, bus.ramData}),
        .ready       (bus.pixelReady),
        .load_ok     (load_ok),
        .pixel       (bus.pixel),
        .valid       (bus.pixelValid),
        .last_accept (last_accept),
        .line_done   (line_done)
    );

    assign bus.lineDone = line_done;
endmodule
